// File: rtl/bcd_to_bin_14bit_if.sv
// bcd_to_bin_14bit_if
//   Request/result bundle for the BCD-to-binary converter.
//   master : drives start/bcd_in, observes busy/done/bin_out/bcd_error
//   slave  : the converter side
//   start     - conversion request (sampled in IDLE only)
//   bcd_in    - four BCD digits, [15:12] thousands .. [3:0] units
//   busy      - conversion in progress
//   done      - one-cycle pulse when a result or error is posted
//   bin_out   - 14-bit binary result, held until the next post
//   bcd_error - set with done when any digit was > 9
interface bcd_to_bin_14bit_if;
    logic        start;
    logic [15:0] bcd_in;
    logic        busy;
    logic        done;
    logic [13:0] bin_out;
    logic        bcd_error;

    modport master (
        output start, bcd_in,
        input  busy, done, bin_out, bcd_error
    );

    modport slave (
        input  start, bcd_in,
        output busy, done, bin_out, bcd_error
    );
endinterface

// File: rtl/bcd_to_bin_14bit.sv
// bcd_to_bin_14bit
//   Sequential 4-digit BCD to 14-bit binary converter (reverse double-dabble).
//   A 30-bit register {bcd[15:0], bin[13:0]} is shifted right once per cycle,
//   after which every BCD nibble >= 8 has 3 subtracted. After 14 shifts the
//   binary half holds the result.
//   Ports:
//     conv_clk_signal - conversion clock, rising edge
//     rst_n           - asynchronous active-low reset
//     bus             - slave side of bcd_to_bin_14bit_if
module bcd_to_bin_14bit (
    input  logic              conv_clk_signal,
    input  logic              rst_n,
    bcd_to_bin_14bit_if.slave bus
);

    localparam int NUM_DIGITS = 4;
    localparam int BIN_W      = 14;
    localparam int SR_W       = NUM_DIGITS * 4 + BIN_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ERR   = 2'd2
    } state_t;

    state_t            state;
    logic [SR_W-1:0]   shift_reg;
    logic [3:0]        iter_cnt;

    logic [SR_W-1:0]   shifted;
    logic [SR_W-1:0]   corrected;
    logic              digit_bad;

    // One iteration: shift right, then nibble-local -3 on any digit >= 8.
    // No borrow crosses a nibble boundary since 8..15 - 3 stays in 5..12.
    always_comb begin
        shifted   = {1'b0, shift_reg[SR_W-1:1]};
        corrected = shifted;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (shifted[BIN_W + 4*i +: 4] >= 4'd8)
                corrected[BIN_W + 4*i +: 4] = shifted[BIN_W + 4*i +: 4] - 4'd3;
        end
    end

    always_comb begin
        digit_bad = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bus.bcd_in[4*i +: 4] > 4'd9)
                digit_bad = 1'b1;
        end
    end

    always_ff @(posedge conv_clk_signal or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            shift_reg     <= '0;
            iter_cnt      <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.bin_out   <= '0;
            bus.bcd_error <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (digit_bad) begin
                            state <= ERR;
                        end else begin
                            shift_reg <= {bus.bcd_in, {BIN_W{1'b0}}};
                            iter_cnt  <= '0;
                            bus.busy  <= 1'b1;
                            state     <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    shift_reg <= corrected;
                    iter_cnt  <= iter_cnt + 4'd1;
                    // iter_cnt == 13 means this edge performs the 14th shift
                    if (iter_cnt == 4'(BIN_W - 1)) begin
                        bus.bin_out   <= corrected[BIN_W-1:0];
                        bus.bcd_error <= 1'b0;
                        bus.done      <= 1'b1;
                        bus.busy      <= 1'b0;
                        state         <= IDLE;
                    end
                end
                ERR: begin
                    bus.bin_out   <= '0;
                    bus.bcd_error <= 1'b1;
                    bus.done      <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin_14bit.sv
module tb_bcd_to_bin_14bit;

    logic conv_clk_signal = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;

    bcd_to_bin_14bit_if bus ();

    bcd_to_bin_14bit dut (
        .conv_clk_signal (conv_clk_signal),
        .rst_n           (rst_n),
        .bus             (bus.slave)
    );

    always #5 conv_clk_signal = ~conv_clk_signal;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Reference: decimal value of the digits, error if any digit > 9.
    function automatic bit ref_err(input logic [15:0] bcd);
        for (int i = 0; i < 4; i++)
            if (int'(bcd[4*i +: 4]) > 9) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int ref_val(input logic [15:0] bcd);
        return int'(bcd[15:12]) * 1000 + int'(bcd[11:8]) * 100 +
               int'(bcd[7:4]) * 10 + int'(bcd[3:0]);
    endfunction

    function automatic logic [15:0] rand_valid_bcd();
        logic [15:0] v;
        for (int i = 0; i < 4; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    // One conversion; inject pulses ignored starts at E5 and E14.
    task automatic run_conv(input logic [15:0] bcd, input bit inject);
        bit err;
        int exp_v, n, busy_cnt;
        bit got;
        err   = ref_err(bcd);
        exp_v = err ? 0 : ref_val(bcd);
        @(negedge conv_clk_signal);
        bus.start  = 1'b1;
        bus.bcd_in = bcd;
        @(posedge conv_clk_signal); #1;              // E0
        bus.start  = 1'b0;
        bus.bcd_in = 16'($urandom);                 // must not affect result
        busy_cnt = bus.busy ? 1 : 0;
        n = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            if (inject && (n + 1 == 5 || n + 1 == 14)) begin
                bus.start  = 1'b1;
                bus.bcd_in = 16'h0007;
            end else begin
                bus.start  = 1'b0;
            end
            @(posedge conv_clk_signal); #1;
            n++;
            if (bus.done) got = 1'b1;
            else if (bus.busy) busy_cnt++;
        end
        bus.start = 1'b0;
        chk("latency", 32'(n), err ? 32'd1 : 32'd14);
        chk("busy_cycles", 32'(busy_cnt), err ? 32'd0 : 32'd14);
        chk("bin_out", 32'(bus.bin_out), 32'(exp_v));
        chk("bcd_error", 32'(bus.bcd_error), 32'(err));
        @(posedge conv_clk_signal); #1;
        chk("done_width", 32'(bus.done), 32'd0);
        chk("bin_hold", 32'(bus.bin_out), 32'(exp_v));
    endtask

    initial begin
        int dones, cyc, last, gap_ok;
        logic [15:0] v;
        bus.start  = 1'b0;
        bus.bcd_in = 16'h0000;
        #12;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_bin", 32'(bus.bin_out), 32'd0);
        chk("rst_err", 32'(bus.bcd_error), 32'd0);
        @(negedge conv_clk_signal);
        rst_n = 1'b1;

        run_conv(16'h9999, 1'b0);
        run_conv(16'h1234, 1'b0);
        run_conv(16'h0000, 1'b0);
        run_conv(16'h0010, 1'b0);
        run_conv(16'h12A4, 1'b0);
        run_conv(16'h0042, 1'b0);
        run_conv(16'h0500, 1'b1);

        // Reset mid-conversion
        @(negedge conv_clk_signal);
        bus.start  = 1'b1;
        bus.bcd_in = 16'h8888;
        @(posedge conv_clk_signal); #1;
        bus.start = 1'b0;
        repeat (7) @(posedge conv_clk_signal);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_bin", 32'(bus.bin_out), 32'd0);
        chk("abort_err", 32'(bus.bcd_error), 32'd0);
        @(negedge conv_clk_signal);
        @(negedge conv_clk_signal);
        rst_n = 1'b1;
        dones = 0;
        repeat (20) begin
            @(posedge conv_clk_signal); #1;
            if (bus.done) dones++;
        end
        chk("abort_no_done", 32'(dones), 32'd0);
        run_conv(16'h0001, 1'b0);

        // Randomized conversions, some with invalid digits
        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 3) == 0) v = 16'($urandom);
            else v = rand_valid_bcd();
            run_conv(v, 1'b0);
        end

        // start held high: one result every 15 cycles
        @(negedge conv_clk_signal);
        bus.start  = 1'b1;
        bus.bcd_in = 16'h0321;
        dones = 0;
        cyc = 0;
        last = 0;
        gap_ok = 1;
        while (dones < 3 && cyc < 80) begin
            @(posedge conv_clk_signal); #1;
            cyc++;
            if (bus.done) begin
                dones++;
                chk("held_bin", 32'(bus.bin_out), 32'd321);
                if (dones == 1) chk("held_first", 32'(cyc), 32'd15);
                else chk("held_gap", 32'(cyc - last), 32'd15);
                last = cyc;
            end
        end
        bus.start = 1'b0;
        chk("held_count", 32'(dones), 32'd3);
        repeat (20) @(posedge conv_clk_signal);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
